// File: rtl/uart_fifo_tx.sv
// 8N1 UART transmitter that pulls bytes from a FIFO with registered read data.
// One-cycle read strobe, one wait cycle for the data, then start/8 data/stop bits.
module uart_fifo_tx #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       EN,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_rd,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
);

    typedef enum logic [2:0] {IDLE, FETCH, WAIT, START, DATA, STOP} state_t;

    localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

    state_t      state, state_n;
    logic [15:0] cnt, cnt_n;
    logic [2:0]  idx, idx_n;
    logic [7:0]  shreg, shreg_n;
    logic        tx_n, rd_n, busy_n, done_n;
    logic        bit_end;

    assign bit_end = (cnt == LAST);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            shreg   <= '0;
            tx      <= 1'b1;
            fifo_rd <= 1'b0;
            busy    <= 1'b0;
            tx_done <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            idx     <= idx_n;
            shreg   <= shreg_n;
            tx      <= tx_n;
            fifo_rd <= rd_n;
            busy    <= busy_n;
            tx_done <= done_n;
        end
    end

    // All outputs are registered: this block computes their next values.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        shreg_n = shreg;
        tx_n    = tx;
        rd_n    = 1'b0;
        busy_n  = busy;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                if (EN && !fifo_empty) begin
                    rd_n    = 1'b1;
                    busy_n  = 1'b1;
                    state_n = FETCH;
                end
            end
            FETCH: state_n = WAIT;
            WAIT: begin
                shreg_n = fifo_data;
                tx_n    = 1'b0;
                cnt_n   = '0;
                state_n = START;
            end
            START: begin
                if (bit_end) begin
                    cnt_n   = '0;
                    tx_n    = shreg[0];
                    state_n = DATA;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_n = '0;
                    if (idx == 3'd7) begin
                        idx_n   = '0;
                        tx_n    = 1'b1;
                        state_n = STOP;
                    end else begin
                        // Bit 0 of the shift register is always the bit on the line.
                        idx_n   = idx + 3'd1;
                        shreg_n = {1'b0, shreg[7:1]};
                        tx_n    = shreg[1];
                    end
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    cnt_n   = '0;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_fifo_tx.sv
// Directed/randomized bench for uart_fifo_tx with a behavioural FIFO and an
// expected-waveform model derived from the 8N1 bit timing.
module tb_uart_fifo_tx;

    localparam int CPB = 4;
    localparam int FRAME = 10 * CPB;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       EN = 1'b1;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_data = 8'h00;
    logic       fifo_rd, tx, busy, tx_done;

    int checks = 0;
    int passes = 0;
    int fails = 0;

    logic [7:0] fq[$];
    bit         glitch = 1'b0;
    int         cyc = 0;
    int         rd_cyc = 0;
    int         rd_count = 0;
    int         underflow = 0;

    always #5 Clk = ~Clk;

    uart_fifo_tx #(.CLKS_PER_BIT(CPB)) dut (
        .Clk(Clk), .Rst(Rst), .EN(EN), .fifo_empty(fifo_empty),
        .fifo_data(fifo_data), .fifo_rd(fifo_rd), .tx(tx),
        .busy(busy), .tx_done(tx_done)
    );

    // FIFO with registered read data; in glitch mode the data bus scrambles on
    // every edge that does not deliver a popped byte.
    always @(posedge Clk) begin
        cyc <= cyc + 1;
        if (fifo_rd) begin
            rd_count <= rd_count + 1;
            rd_cyc   <= cyc;
            if (fq.size() == 0) underflow <= underflow + 1;
            else fifo_data <= fq.pop_front();
        end else if (glitch) begin
            fifo_data <= 8'($urandom);
        end
        fifo_empty <= (fq.size() == 0);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Waits for a start bit and compares every cycle of the frame against the
    // 8N1 waveform of exp. drop_at/rst_at (frame cycle index, -1 = never)
    // drop EN or pulse Rst at that cycle.
    task automatic check_frame(input logic [7:0] exp, input int drop_at,
                               input int rst_at, output int fall_cyc);
        int  t;
        int  k;
        bit  ok;
        logic exp_tx;
        string tag;
        tag = $sformatf("frame_%02h", exp);
        fall_cyc = 0;
        t = 0;
        while (tx !== 1'b0 && t < 300) begin
            @(negedge Clk);
            t++;
        end
        check({tag, "_start_timeout"}, 32'(t < 300), 32'd1);
        if (t >= 300) return;
        fall_cyc = cyc;
        check({tag, "_rd_to_start"}, 32'(cyc - rd_cyc), 32'd2);
        ok = 1'b1;
        for (int i = 0; i < FRAME; i++) begin
            k = i / CPB;
            exp_tx = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : exp[k-1];
            if (tx !== exp_tx || busy !== 1'b1 || tx_done !== 1'b0 || fifo_rd !== 1'b0)
                ok = 1'b0;
            if (i == drop_at) EN = 1'b0;
            if (i == rst_at) begin
                check({tag, "_before_rst"}, 32'(ok), 32'd1);
                Rst = 1'b1;
                @(negedge Clk);
                check({tag, "_after_rst"}, 32'({tx, busy, tx_done, fifo_rd}), 32'b1000);
                Rst = 1'b0;
                return;
            end
            @(negedge Clk);
        end
        check({tag, "_wave"}, 32'(ok), 32'd1);
        check({tag, "_done"}, 32'({tx, busy, tx_done}), 32'b101);
        @(negedge Clk);
        check({tag, "_done_width"}, 32'(tx_done), 32'd0);
    endtask

    initial begin
        int f0, f1, f2, fx;
        bit ok;
        logic [7:0] b[3];

        // Reset holds off a queued byte even with EN=1.
        fq.push_back(8'hA5);
        ok = 1'b1;
        @(negedge Clk);
        for (int i = 0; i < 5; i++) begin
            if ({tx, busy, fifo_rd, tx_done} !== 4'b1000) ok = 1'b0;
            @(negedge Clk);
        end
        check("reset_state", 32'(ok), 32'd1);
        check("reset_no_rd", 32'(rd_count), 32'd0);
        Rst = 1'b0;

        check_frame(8'hA5, -1, -1, f0);
        check("single_rd_count", 32'(rd_count), 32'd1);

        // Empty FIFO with EN high: nothing happens.
        ok = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge Clk);
            if (fifo_rd !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) ok = 1'b0;
        end
        check("empty_idle", 32'(ok), 32'd1);
        check("empty_rd_count", 32'(rd_count), 32'd1);

        // Back-to-back frames with the minimum gap.
        fq.push_back(8'h00);
        fq.push_back(8'hFF);
        fq.push_back(8'h55);
        check_frame(8'h00, -1, -1, f0);
        check_frame(8'hFF, -1, -1, f1);
        check_frame(8'h55, -1, -1, f2);
        check("gap_00_ff", 32'(f1 - f0), 32'(FRAME + 3));
        check("gap_ff_55", 32'(f2 - f1), 32'(FRAME + 3));
        check("burst_rd_count", 32'(rd_count), 32'd4);

        // Random bytes with the data bus scrambled outside the capture cycle.
        for (int i = 0; i < 3; i++) begin
            b[i] = 8'($urandom);
            fq.push_back(b[i]);
        end
        glitch = 1'b1;
        check_frame(b[0], -1, -1, f0);
        check_frame(b[1], -1, -1, f1);
        check_frame(b[2], -1, -1, f2);
        glitch = 1'b0;
        check("rand_gap_1", 32'(f1 - f0), 32'(FRAME + 3));
        check("rand_gap_2", 32'(f2 - f1), 32'(FRAME + 3));
        check("rand_rd_count", 32'(rd_count), 32'd7);

        // EN dropped during data bit 3: frame completes, second byte waits.
        b[0] = 8'($urandom);
        b[1] = 8'($urandom);
        fq.push_back(b[0]);
        fq.push_back(b[1]);
        check_frame(b[0], 4 * CPB + 1, -1, f0);
        ok = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge Clk);
            if (fifo_rd !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) ok = 1'b0;
        end
        check("en_low_idle", 32'(ok), 32'd1);
        check("en_low_rd_count", 32'(rd_count), 32'd8);
        EN = 1'b1;
        check_frame(b[1], -1, -1, f1);
        check("en_resume_rd_count", 32'(rd_count), 32'd9);

        // Reset during data bit 5 aborts; next queued byte goes out whole.
        b[0] = 8'($urandom);
        b[1] = 8'($urandom);
        fq.push_back(b[0]);
        fq.push_back(b[1]);
        check_frame(b[0], -1, 6 * CPB + 1, f0);
        check_frame(b[1], -1, -1, f1);
        check("rst_data_rd_count", 32'(rd_count), 32'd11);

        // Reset during FETCH discards the byte already read.
        EN = 1'b0;
        b[0] = 8'($urandom);
        b[1] = 8'($urandom);
        fq.push_back(b[0]);
        fq.push_back(b[1]);
        repeat (3) @(negedge Clk);
        EN = 1'b1;
        fx = 0;
        while (fifo_rd !== 1'b1 && fx < 20) begin
            @(negedge Clk);
            fx++;
        end
        check("fetch_seen", 32'(fx < 20), 32'd1);
        Rst = 1'b1;
        @(negedge Clk);
        check("fetch_rst_state", 32'({fifo_rd, busy, tx}), 32'b001);
        Rst = 1'b0;
        check_frame(b[1], -1, -1, f1);
        check("fetch_rst_rd_count", 32'(rd_count), 32'd13);
        check("no_underflow", 32'(underflow), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
